// File: rtl/covert_pkg.sv
// Shared definitions for the thermal covert channel: FSM encoding, default
// timing parameters and the Manchester level helper.
package covert_pkg;

  localparam int DEF_HALF_CYCLES  = 25_000_000;
  localparam int DEF_PREAMBLE_LEN = 4;
  localparam int DEF_GUARD_HALVES = 4;
  localparam int DEF_CNT_W        = 32;

  // Heater level of the first half when the bit is 1
  localparam logic MANCH_ONE_FIRST = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_GUARD    = 3'd4
  } state_t;

  // Heater level for a bit value in its first (half=0) or second (half=1) half
  function automatic logic manch_level(input logic b, input logic half);
    return half ^ (b ? MANCH_ONE_FIRST : ~MANCH_ONE_FIRST);
  endfunction

endpackage

// File: rtl/half_period_timer.sv
// Down-counter measuring one Manchester half-period; expire pulses for the
// single cycle the count sits at zero while enabled.
module half_period_timer #(
  parameter int CNT_W       = 32,
  parameter int HALF_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  // Load has priority so the half that follows an expiry starts at full length
  always_ff @(posedge clk) begin
    if (!reset)                 cnt <= '0;
    else if (load)              cnt <= CNT_W'(HALF_CYCLES - 1);
    else if (en && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign expire = en && (cnt == '0);

endmodule

// File: rtl/thermal_frame_modulator.sv
// Turns one accepted byte into a Manchester-coded heater on/off frame:
// preamble, 8 data bits LSB first, even parity, then a heater-off guard.
module thermal_frame_modulator
  import covert_pkg::*;
#(
  parameter int HALF_CYCLES  = DEF_HALF_CYCLES,
  parameter int PREAMBLE_LEN = DEF_PREAMBLE_LEN,
  parameter int GUARD_HALVES = DEF_GUARD_HALVES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       abort,
  output logic       heater_en,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] state_dbg
);

  localparam int MAXN = (PREAMBLE_LEN > GUARD_HALVES)
                        ? ((PREAMBLE_LEN > 8) ? PREAMBLE_LEN : 8)
                        : ((GUARD_HALVES > 8) ? GUARD_HALVES : 8);
  localparam int IW   = $clog2(MAXN) + 1;

  state_t          state, state_d;
  logic            half, half_d;
  logic [IW-1:0]   idx, idx_d;      // bit index in PREAMBLE/DATA, half index in GUARD
  logic [7:0]      data_q;
  logic            heater_d, nbit;
  logic            load, en, expire, accept, active_d;

  half_period_timer #(.CNT_W(CNT_W), .HALF_CYCLES(HALF_CYCLES)) u_timer (
    .clk(clk), .reset(reset), .load(load), .en(en), .expire(expire)
  );

  assign accept     = tx_valid && (state == S_IDLE);
  assign tx_ready   = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign state_dbg  = state;
  assign frame_done = (state == S_GUARD) && expire && (idx == IW'(GUARD_HALVES - 1));

  // Next-state: advance half/bit on timer expiry, abort diverts to guard
  always_comb begin
    state_d = state;
    half_d  = half;
    idx_d   = idx;
    load    = 1'b0;
    en      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_d = S_PREAMBLE;
          half_d  = 1'b0;
          idx_d   = '0;
          load    = 1'b1;
        end
      end
      S_PREAMBLE, S_DATA, S_PARITY: begin
        en = 1'b1;
        if (abort) begin
          state_d = S_GUARD;
          half_d  = 1'b0;
          idx_d   = '0;
          load    = 1'b1;
        end else if (expire) begin
          load = 1'b1;
          if (!half) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            idx_d  = idx + 1'b1;
            if (state == S_PREAMBLE && idx == IW'(PREAMBLE_LEN - 1)) begin
              state_d = S_DATA;
              idx_d   = '0;
            end else if (state == S_DATA && idx == IW'(7)) begin
              state_d = S_PARITY;
              idx_d   = '0;
            end else if (state == S_PARITY) begin
              state_d = S_GUARD;
              idx_d   = '0;
            end
          end
        end
      end
      S_GUARD: begin
        en = 1'b1;
        if (expire) begin
          load = 1'b1;
          if (idx == IW'(GUARD_HALVES - 1)) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Heater level for the half that starts at the coming edge
  always_comb begin
    nbit     = 1'b0;
    active_d = 1'b0;
    unique case (state_d)
      S_PREAMBLE: begin nbit = ~idx_d[0];         active_d = 1'b1; end
      S_DATA:     begin nbit = data_q[idx_d[2:0]]; active_d = 1'b1; end
      S_PARITY:   begin nbit = ^data_q;            active_d = 1'b1; end
      default:    begin nbit = 1'b0;               active_d = 1'b0; end
    endcase
    heater_d = active_d ? manch_level(nbit, half_d) : 1'b0;
  end

  // State, counters, latched byte and registered heater drive
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      half      <= 1'b0;
      idx       <= '0;
      data_q    <= '0;
      heater_en <= 1'b0;
    end else begin
      state     <= state_d;
      half      <= half_d;
      idx       <= idx_d;
      heater_en <= heater_d;
      if (accept) data_q <= tx_data;
    end
  end

endmodule
